// File: rtl/i3c_crc_pkg.sv
// Shared CRC5 constants and receive-checker state type for the HDR-DDR CRC path.
package i3c_crc_pkg;

  localparam int unsigned CRC5_W      = 5;
  localparam logic [4:0]  CRC5_POLY   = 5'b00101;
  localparam logic [4:0]  CRC5_SEED   = 5'b11111;
  localparam int unsigned CRC5_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT    = 3'd1,
    ACCUM    = 3'd2,
    WAIT_CRC = 3'd3,
    DONE     = 3'd4
  } crc_state_e;

endpackage

// File: rtl/crc5_bit_step.sv
// One-bit CRC5 LFSR update, MSB-first; shared by the transmit generator and this checker.
module crc5_bit_step
  import i3c_crc_pkg::*;
#(
  parameter logic [CRC5_W-1:0] POLY = CRC5_POLY
) (
  input  logic [CRC5_W-1:0] crc_i,
  input  logic              bit_i,
  output logic [CRC5_W-1:0] crc_o
);

  logic fb;

  assign fb    = crc_i[CRC5_W-1] ^ bit_i;
  assign crc_o = {crc_i[CRC5_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc5_rx_checker.sv
// Receive-side CRC5 checker: shifts each accepted byte through the LFSR MSB first,
// then compares the accumulated CRC with the received CRC field.
//
// state    | meaning
// IDLE     | register at seed, waiting for first byte or an empty-frame CRC
// SHIFT    | one data bit per cycle into the LFSR
// ACCUM    | byte done, frame not closed; next byte or CRC accepted
// WAIT_CRC | last byte done, waiting for the CRC field
// DONE     | one-cycle result pulse, then back to IDLE
module crc5_rx_checker
  import i3c_crc_pkg::*;
#(
  parameter logic [CRC5_W-1:0] POLY   = CRC5_POLY,
  parameter logic [CRC5_W-1:0] SEED   = CRC5_SEED,
  parameter int unsigned       DATA_W = CRC5_DATA_W
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_enable,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_data_valid,
  input  logic              i_data_last,
  output logic              o_data_ready,
  input  logic [CRC5_W-1:0] i_crc_in,
  input  logic              i_crc_valid,
  output logic              o_crc_ready,
  output logic [CRC5_W-1:0] o_crc_value,
  output logic              o_crc_done,
  output logic              o_crc_err,
  output logic              o_busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  crc_state_e        state_q, state_d;
  logic [CRC5_W-1:0] crc_q, crc_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [CRC5_W-1:0] crc_step;
  logic              data_rdy, crc_rdy, done;

  crc5_bit_step #(.POLY(POLY)) u_step (
    .crc_i (crc_q),
    .bit_i (byte_q[DATA_W-1]),
    .crc_o (crc_step)
  );

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q   <= IDLE;
      crc_q     <= SEED;
      bit_cnt_q <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    last_d    = last_q;
    err_d     = err_q;
    data_rdy  = 1'b0;
    crc_rdy   = 1'b0;
    done      = 1'b0;

    if (i_abort) begin
      state_d   = IDLE;
      crc_d     = SEED;
      bit_cnt_d = '0;
      err_d     = 1'b0;
    end else if (i_enable) begin
      unique case (state_q)
        IDLE: begin
          data_rdy = 1'b1;
          crc_rdy  = 1'b1;
          crc_d    = SEED;
          // A byte beats a simultaneous CRC; the CRC must be presented again.
          if (i_data_valid) begin
            byte_d    = i_data_in;
            last_d    = i_data_last;
            bit_cnt_d = '0;
            state_d   = SHIFT;
          end else if (i_crc_valid) begin
            err_d   = (i_crc_in != SEED);
            state_d = DONE;
          end
        end
        SHIFT: begin
          crc_d     = crc_step;
          byte_d    = {byte_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_LAST) begin
            bit_cnt_d = '0;
            state_d   = last_q ? WAIT_CRC : ACCUM;
          end
        end
        ACCUM: begin
          data_rdy = 1'b1;
          crc_rdy  = 1'b1;
          if (i_data_valid) begin
            byte_d    = i_data_in;
            last_d    = i_data_last;
            bit_cnt_d = '0;
            state_d   = SHIFT;
          end else if (i_crc_valid) begin
            err_d   = (i_crc_in != crc_q);
            state_d = DONE;
          end
        end
        WAIT_CRC: begin
          crc_rdy = 1'b1;
          if (i_crc_valid) begin
            err_d   = (i_crc_in != crc_q);
            state_d = DONE;
          end
        end
        DONE: begin
          done    = 1'b1;
          crc_d   = SEED;
          state_d = IDLE;
        end
        default: begin
          state_d   = IDLE;
          crc_d     = SEED;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  // Readies are also masked by reset so every handshake output reads 0 while it is held.
  assign o_data_ready = data_rdy & i_sys_rst;
  assign o_crc_ready  = crc_rdy & i_sys_rst;
  assign o_crc_done   = done;
  assign o_crc_err    = err_q;
  assign o_crc_value  = crc_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_crc5_rx_checker.sv
// Directed bench for crc5_rx_checker with a transaction-level CRC model and per-cycle compare.
module tb_crc5_rx_checker;

  localparam logic [4:0] SEED = 5'h1F;
  localparam int BIG = 32'h7FFF_FFFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_enable = 1'b1;
  logic       i_abort = 1'b0;
  logic [7:0] i_data_in = '0;
  logic       i_data_valid = 1'b0;
  logic       i_data_last = 1'b0;
  logic [4:0] i_crc_in = '0;
  logic       i_crc_valid = 1'b0;
  logic       o_data_ready, o_crc_ready, o_crc_done, o_crc_err, o_busy;
  logic [4:0] o_crc_value;

  crc5_rx_checker dut (
    .i_sys_clk    (clk),
    .i_sys_rst    (rst_n),
    .i_enable     (i_enable),
    .i_abort      (i_abort),
    .i_data_in    (i_data_in),
    .i_data_valid (i_data_valid),
    .i_data_last  (i_data_last),
    .o_data_ready (o_data_ready),
    .i_crc_in     (i_crc_in),
    .i_crc_valid  (i_crc_valid),
    .o_crc_ready  (o_crc_ready),
    .o_crc_value  (o_crc_value),
    .o_crc_done   (o_crc_done),
    .o_crc_err    (o_crc_err),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model state
  logic [4:0] mdl_crc = SEED;
  logic       pend_err = 1'b0;
  logic       cur_err = 1'b0;
  int         exp_done_cyc = -1;
  int         idle_from = 0;
  int         accept_cyc = 0;
  bit         chk_en = 1'b0;

  // CRC as polynomial remainder: (crc*x^8 + data*x^5) mod (x^5+x^2+1)
  function automatic logic [4:0] crc_byte(input logic [4:0] c, input logic [7:0] d);
    logic [12:0] v;
    v = {c, 8'h00} ^ {d, 5'h00};
    for (int i = 12; i >= 5; i--)
      if (v[i]) v = v ^ (13'b100101 << (i - 5));
    return v[4:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout waiting for DUT (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc == exp_done_cyc) cur_err = pend_err;
      check("done", {31'd0, o_crc_done}, {31'd0, cyc == exp_done_cyc});
      check("err", {31'd0, o_crc_err}, {31'd0, cur_err});
      check("busy", {31'd0, o_busy}, {31'd0, cyc < idle_from});
      if (cyc >= idle_from) check("idle_crc", {27'd0, o_crc_value}, {27'd0, SEED});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    i_data_in = b;
    i_data_last = last;
    i_data_valid = 1'b1;
    while (!o_data_ready && n < 60) begin tick(1); n++; end
    if (n >= 60) begin
      timeout_fail("send_byte");
      i_data_valid = 1'b0;
      return;
    end
    tick(1);
    i_data_valid = 1'b0;
    accept_cyc = cyc;
    idle_from = BIG;
    mdl_crc = crc_byte(mdl_crc, b);
  endtask

  task automatic send_crc(input logic [4:0] c);
    int n = 0;
    i_crc_in = c;
    i_crc_valid = 1'b1;
    while (!o_crc_ready && n < 60) begin tick(1); n++; end
    if (n >= 60) begin
      timeout_fail("send_crc");
      i_crc_valid = 1'b0;
      return;
    end
    tick(1);
    i_crc_valid = 1'b0;
    exp_done_cyc = cyc;
    pend_err = (c != mdl_crc);
    idle_from = cyc + 1;
    mdl_crc = SEED;
  endtask

  task automatic wait_crc_ready(input string nm);
    int n = 0;
    while (!o_crc_ready && n < 60) begin tick(1); n++; end
    if (n >= 60) timeout_fail(nm);
  endtask

  logic [4:0] v, c5a;
  int k, k1;

  initial begin
    check("model_pin_00", {27'd0, crc_byte(SEED, 8'h00)}, 32'h0F);
    tick(2);
    check("rst_value", {27'd0, o_crc_value}, 32'h1F);
    check("rst_ready", {30'd0, o_data_ready, o_crc_ready}, 32'h0);
    check("rst_busy_done_err", {29'd0, o_busy, o_crc_done, o_crc_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk_en = 1'b1;
    idle_from = 0;
    tick(2);

    // good frame
    send_byte(8'h00, 1'b1);
    wait_crc_ready("good_wait");
    check("good_value", {27'd0, o_crc_value}, 32'h0F);
    send_crc(5'h0F);
    tick(3);

    // bad frame, error held while idle
    send_byte(8'h00, 1'b1);
    send_crc(5'h0E);
    tick(1);
    check("bad_err_lit", {31'd0, o_crc_err}, 32'h1);
    tick(5);

    // empty frames
    send_crc(5'h1F);
    tick(3);
    send_crc(5'h00);
    tick(3);

    // abort at bit 4 of 8'hA5 clears the held error
    send_byte(8'hA5, 1'b1);
    tick(4);
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    idle_from = cyc;
    mdl_crc = SEED;
    cur_err = 1'b0;
    check("abort_value", {27'd0, o_crc_value}, 32'h1F);
    tick(2);
    send_byte(8'h00, 1'b1);
    send_crc(5'h0F);
    tick(2);

    // two-byte frame, back-to-back throughput
    send_byte(8'hA5, 1'b0);
    k1 = accept_cyc;
    send_byte(8'h3C, 1'b1);
    check("byte_spacing", accept_cyc - k1, 32'd9);
    wait_crc_ready("multi_wait");
    check("multi_value", {27'd0, o_crc_value}, {27'd0, mdl_crc});
    send_crc(mdl_crc);
    tick(2);

    // byte and CRC together: byte wins, CRC held off through SHIFT, taken in ACCUM
    c5a = crc_byte(SEED, 8'h5A);
    i_crc_in = c5a;
    i_crc_valid = 1'b1;
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 7; i++) begin
      check("shift_crc_ready", {31'd0, o_crc_ready}, 32'h0);
      tick(1);
    end
    send_crc(c5a);
    tick(2);

    // enable stall mid-SHIFT
    send_byte(8'hA5, 1'b1);
    k = accept_cyc;
    tick(3);
    v = o_crc_value;
    i_enable = 1'b0;
    #1;
    check("stall_readies", {30'd0, o_data_ready, o_crc_ready}, 32'h0);
    tick(3);
    check("stall_hold", {27'd0, o_crc_value}, {27'd0, v});
    i_enable = 1'b1;
    wait_crc_ready("stall_wait");
    check("stall_latency", cyc - k, 32'd11);
    check("stall_value", {27'd0, o_crc_value}, {27'd0, crc_byte(SEED, 8'hA5)});
    send_crc(mdl_crc ^ 5'h01);
    tick(3);

    // reset mid-SHIFT while an error is held
    send_byte(8'h00, 1'b1);
    tick(3);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_value", {27'd0, o_crc_value}, 32'h1F);
    check("midrst_busy_done_err", {29'd0, o_busy, o_crc_done, o_crc_err}, 32'h0);
    check("midrst_ready", {30'd0, o_data_ready, o_crc_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    cur_err = 1'b0;
    idle_from = 0;
    exp_done_cyc = -1;
    mdl_crc = SEED;
    chk_en = 1'b1;
    send_byte(8'h00, 1'b1);
    send_crc(5'h0F);
    tick(3);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
